// File: rtl/reg_port_sched.sv
// reg_port_sched: owns the single register-file access port and shares it
// between the CPU execute/writeback path (A) and the move/exchange unit (B).
// A normally wins. B is forced ahead after STARVE_MAX consecutive A grants.
// A granted B swap locks the port for its full read/read/write/write sequence.
module reg_port_sched #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [1:0]        b_op,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] b_addr2,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic              rf_load,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] rf_out
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SW_RD1 = 3'd1,
    SW_RD2 = 3'd2,
    SW_WR1 = 3'd3,
    SW_WR2 = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] sw_addr1;
  logic [ADDR_W-1:0] sw_addr2;
  logic [DATA_W-1:0] tmp1;
  logic              a_rd_pend;
  logic              b_rd_pend;
  logic              b_first;
  logic              swap_start;

  assign busy       = (state != IDLE);
  assign swap_start = b_gnt && (b_op == OP_SWAP);

  // Arbitration: one grant per cycle, only while idle and out of reset; B wins when A is absent or B has starved.
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    b_first = b_req && (!a_req || (starve_cnt == STARVE_LIM));
    if (!rst && (state == IDLE)) begin
      if (b_first) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
  end

  // Swap sequencer next-state: only a granted swap leaves IDLE, then four locked cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (swap_start) state_nxt = SW_RD1;
      SW_RD1:  state_nxt = SW_RD2;
      SW_RD2:  state_nxt = SW_WR1;
      SW_WR1:  state_nxt = SW_WR2;
      SW_WR2:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Swap sequencer state register; reset abandons any swap in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Register-file port mux: grant-cycle access from the winner, otherwise the swap's own accesses.
  always_comb begin
    rf_load = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (!rst) begin
      if (a_gnt) begin
        rf_load = a_we;
        rf_addr = a_addr;
        rf_data = a_we ? a_wdata : '0;
      end else if (b_gnt) begin
        case (b_op)
          OP_RD: begin
            rf_addr = b_addr;
          end
          OP_WR: begin
            rf_load = 1'b1;
            rf_addr = b_addr;
            rf_data = b_wdata;
          end
          OP_SWAP: begin
            rf_addr = b_addr;
          end
          default: begin
          end
        endcase
      end else begin
        case (state)
          SW_RD1: begin
            rf_addr = sw_addr2;
          end
          SW_RD2: begin
            rf_load = 1'b1;
            rf_addr = sw_addr1;
            rf_data = rf_out;
          end
          SW_WR1: begin
            rf_load = 1'b1;
            rf_addr = sw_addr2;
            rf_data = tmp1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Starvation counter: counts A grants that B watched go by, cleared once B is served or stops asking.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (b_gnt || !b_req) begin
      starve_cnt <= '0;
    end else if (a_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Swap operand capture: indices frozen at grant, first read value held until the final write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_addr1 <= '0;
      sw_addr2 <= '0;
      tmp1     <= '0;
    end else begin
      if (swap_start) begin
        sw_addr1 <= b_addr;
        sw_addr2 <= b_addr2;
      end
      if (state == SW_RD1) begin
        tmp1 <= rf_out;
      end
    end
  end

  // A response path: read data arrives the cycle after issue and is presented one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_pend <= 1'b0;
      a_rvalid  <= 1'b0;
      a_rdata   <= '0;
    end else begin
      a_rd_pend <= a_gnt && !a_we;
      a_rvalid  <= a_rd_pend;
      if (a_rd_pend) begin
        a_rdata <= rf_out;
      end
    end
  end

  // B completion path: reads finish like A reads, writes/no-ops the cycle after grant, swaps after SW_WR1.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rd_pend <= 1'b0;
      b_done    <= 1'b0;
      b_rdata   <= '0;
    end else begin
      b_rd_pend <= b_gnt && (b_op == OP_RD);
      b_done    <= b_rd_pend
                   || (b_gnt && ((b_op == OP_WR) || (b_op == OP_NOP)))
                   || (state == SW_WR1);
      if (b_rd_pend) begin
        b_rdata <= rf_out;
      end
    end
  end

endmodule

// File: tb/tb_reg_port_sched.sv
// tb_reg_port_sched: drives both requesters against a behavioural register
// file, predicts read data from a shadow copy of the registers, and checks
// response pulses through scoreboard queues plus per-scenario timing checks.
module tb_reg_port_sched;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic          chk;
    logic [DW-1:0] d;
  } bexp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req;
  logic [1:0]    b_op;
  logic [AW-1:0] b_addr, b_addr2;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_done;
  logic [DW-1:0] b_rdata;
  logic          busy;
  logic          rf_load;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] rf_out = '0;

  logic [DW-1:0] rf_mem [16] = '{default: '0};
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] exp_a [$];
  bexp_t         exp_b [$];

  int checks = 0;
  int errors = 0;

  reg_port_sched dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_addr2(b_addr2),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .busy(busy), .rf_load(rf_load), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file: write on load, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (rf_load === 1'b1) rf_mem[rf_addr] <= rf_data;
    rf_out <= rf_mem[rf_addr];
  end

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [DW-1:0] ea;
    bexp_t         eb;
    if (a_rvalid === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL a_rvalid_unexpected: got pulse with a_rdata=%h, expected no pulse", a_rdata);
      end else begin
        ea = exp_a.pop_front();
        if (a_rdata !== ea) begin
          errors++;
          $display("[TB] FAIL a_rdata: got %h, expected %h", a_rdata, ea);
        end
      end
    end
    if (b_done === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL b_done_unexpected: got pulse, expected no pulse");
      end else begin
        eb = exp_b.pop_front();
        if (eb.chk && (b_rdata !== eb.d)) begin
          errors++;
          $display("[TB] FAIL b_rdata: got %h, expected %h", b_rdata, eb.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Issue one A access and wait (bounded) for its grant; ends one cycle after the grant.
  task automatic apply_a_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit granted = 0;
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    for (int n = 0; n < 50 && !granted; n++) begin
      @(negedge clk);
      if (a_gnt === 1'b1) granted = 1;
    end
    if (!granted) begin
      checks++; errors++;
      $display("[TB] FAIL a_gnt_timeout: got no grant in 50 cycles, expected a grant");
    end else if (we) begin
      shadow[addr] = data;
    end else begin
      exp_a.push_back(shadow[addr]);
    end
    tick();
    a_req = 1'b0;
  endtask

  // Issue one B operation and wait (bounded) for its grant; predicts its effect on the registers.
  task automatic apply_b_access(input logic [1:0] op, input logic [AW-1:0] addr,
                                input logic [AW-1:0] addr2, input logic [DW-1:0] data);
    bit granted = 0;
    logic [DW-1:0] t;
    b_req = 1'b1; b_op = op; b_addr = addr; b_addr2 = addr2; b_wdata = data;
    for (int n = 0; n < 50 && !granted; n++) begin
      @(negedge clk);
      if (b_gnt === 1'b1) granted = 1;
    end
    if (!granted) begin
      checks++; errors++;
      $display("[TB] FAIL b_gnt_timeout: got no grant in 50 cycles, expected a grant");
    end else begin
      case (op)
        2'b00: exp_b.push_back(bexp_t'{1'b1, shadow[addr]});
        2'b01: begin shadow[addr] = data; exp_b.push_back(bexp_t'{1'b0, 16'h0}); end
        2'b10: begin
          t = shadow[addr]; shadow[addr] = shadow[addr2]; shadow[addr2] = t;
          exp_b.push_back(bexp_t'{1'b0, 16'h0});
        end
        default: exp_b.push_back(bexp_t'{1'b0, 16'h0});
      endcase
    end
    tick();
    b_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 16'hFFFF;
    b_req = 1'b1; b_op = 2'b01; b_addr = 4'd2; b_addr2 = 4'd0; b_wdata = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_gnt: got %b, expected 0", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_gnt: got %b, expected 0", b_gnt); end
    checks++; if (rf_load !== 1'b0) begin errors++; $display("[TB] FAIL rst_rf_load: got %b, expected 0", rf_load); end
    tick();
    a_req = 1'b0; b_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_rvalid: got %b, expected 0", a_rvalid); end
    checks++; if (b_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_done: got %b, expected 0", b_done); end
    checks++; if (a_rdata !== 16'h0) begin errors++; $display("[TB] FAIL rst_a_rdata: got %h, expected 0000", a_rdata); end
    checks++; if (b_rdata !== 16'h0) begin errors++; $display("[TB] FAIL rst_b_rdata: got %h, expected 0000", b_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    tick();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 16'h1234;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt: got %b, expected 1", a_gnt); end
    shadow[3] = 16'h1234;
    tick();
    a_we = 1'b0;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt: got %b, expected 1", a_gnt); end
    exp_a.push_back(16'h1234);
    tick();
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_rvalid: got %b, expected 0", a_rvalid); end
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_rvalid_t3: got %b, expected 1", a_rvalid); end
    checks++; if (a_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL rd_data_t3: got %h, expected 1234", a_rdata); end
    tick();
  endtask

  task automatic test_swap();
    apply_a_access(1'b1, 4'd1, 16'd1000);
    apply_a_access(1'b1, 4'd2, 16'd100);
    b_req = 1'b1; b_op = 2'b10; b_addr = 4'd1; b_addr2 = 4'd2;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("[TB] FAIL swap_gnt: got %b, expected 1", b_gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL swap_busy_t0: got %b, expected 0", busy); end
    shadow[1] = 16'd100; shadow[2] = 16'd1000;
    exp_b.push_back(bexp_t'{1'b0, 16'h0});
    tick();
    b_req = 1'b0; b_op = 2'b01; b_addr = 4'd5; b_addr2 = 4'd7;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL swap_busy_t%0d: got %b, expected 1", k, busy); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("[TB] FAIL swap_lock_t%0d: got a_gnt=%b, expected 0", k, a_gnt); end
      checks++; if (b_done !== (k == 4)) begin errors++; $display("[TB] FAIL swap_done_t%0d: got %b, expected %b", k, b_done, (k == 4)); end
    end
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("[TB] FAIL swap_after_gnt: got %b, expected 1", a_gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL swap_after_busy: got %b, expected 0", busy); end
    exp_a.push_back(16'd100);
    tick();
    a_addr = 4'd2;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("[TB] FAIL swap_rd2_gnt: got %b, expected 1", a_gnt); end
    exp_a.push_back(16'd1000);
    tick();
    a_req = 1'b0;
    drain(4);
  endtask

  task automatic test_starvation();
    int  a_cnt;
    bit  got;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
    b_req = 1'b1; b_op = 2'b01; b_addr = 4'd8; b_wdata = 16'h0BEE;
    for (int round = 0; round < 2; round++) begin
      a_cnt = 0; got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (a_gnt === 1'b1) begin exp_a.push_back(shadow[0]); a_cnt++; end
        if (b_gnt === 1'b1) got = 1;
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL starve_b_gnt_r%0d: got no B grant, expected one", round); end
      checks++; if (a_cnt != 4) begin errors++; $display("[TB] FAIL starve_a_count_r%0d: got %0d, expected 4", round, a_cnt); end
      if (got) begin
        shadow[8] = b_wdata;
        exp_b.push_back(bexp_t'{1'b0, 16'h0});
      end
      tick();
      b_wdata = 16'h0C0D;
    end
    a_req = 1'b0; b_req = 1'b0;
    drain(4);
    apply_b_access(2'b00, 4'd8, 4'd0, 16'h0);
    drain(3);
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd10; a_wdata = 16'hA5A5;
    b_req = 1'b1; b_op = 2'b01; b_addr = 4'd5; b_wdata = 16'h0007;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("[TB] FAIL tie_a_gnt: got %b, expected 1", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_b_wait: got %b, expected 0", b_gnt); end
    shadow[10] = 16'hA5A5;
    tick();
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("[TB] FAIL tie_b_gnt: got %b, expected 1", b_gnt); end
    checks++; if ((rf_load !== 1'b1) || (rf_addr !== 4'd5) || (rf_data !== 16'h0007)) begin
      errors++; $display("[TB] FAIL tie_b_issue: got load=%b addr=%h data=%h, expected 1/5/0007", rf_load, rf_addr, rf_data);
    end
    shadow[5] = 16'h0007;
    exp_b.push_back(bexp_t'{1'b0, 16'h0});
    tick();
    b_req = 1'b0;
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("[TB] FAIL tie_b_done: got %b, expected 1", b_done); end
    tick();
    apply_b_access(2'b00, 4'd5, 4'd0, 16'h0);
    apply_a_access(1'b0, 4'd10, 16'h0);
    drain(4);
  endtask

  task automatic test_reset_mid_swap();
    apply_a_access(1'b1, 4'd4, 16'h4444);
    apply_a_access(1'b1, 4'd6, 16'h6666);
    drain(1);
    b_req = 1'b1; b_op = 2'b10; b_addr = 4'd4; b_addr2 = 4'd6;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rsw_gnt: got %b, expected 1", b_gnt); end
    tick();
    b_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if ((rf_load !== 1'b1) || (rf_addr !== 4'd4) || (rf_data !== 16'h6666)) begin
      errors++; $display("[TB] FAIL rsw_wr1_issue: got load=%b addr=%h data=%h, expected 1/4/6666", rf_load, rf_addr, rf_data);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rf_load !== 1'b0) begin errors++; $display("[TB] FAIL rsw_load_in_rst: got %b, expected 0", rf_load); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rsw_busy_%0d: got %b, expected 0", k, busy); end
      checks++; if (b_done !== 1'b0) begin errors++; $display("[TB] FAIL rsw_done_%0d: got %b, expected 0", k, b_done); end
      checks++; if (rf_load !== 1'b0) begin errors++; $display("[TB] FAIL rsw_load_%0d: got %b, expected 0", k, rf_load); end
    end
    shadow[4] = 16'h6666;
    tick();
    apply_a_access(1'b0, 4'd4, 16'h0);
    apply_a_access(1'b0, 4'd6, 16'h0);
    drain(4);
  endtask

  task automatic test_swap_same_and_nop();
    apply_a_access(1'b1, 4'd9, 16'h00FF);
    b_req = 1'b1; b_op = 2'b10; b_addr = 4'd9; b_addr2 = 4'd9;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("[TB] FAIL same_gnt: got %b, expected 1", b_gnt); end
    exp_b.push_back(bexp_t'{1'b0, 16'h0});
    tick();
    b_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (b_done !== (k == 4)) begin errors++; $display("[TB] FAIL same_done_t%0d: got %b, expected %b", k, b_done, (k == 4)); end
    end
    tick();
    apply_a_access(1'b0, 4'd9, 16'h0);
    drain(3);
    b_req = 1'b1; b_op = 2'b11; b_addr = 4'd3;
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("[TB] FAIL nop_gnt: got %b, expected 1", b_gnt); end
    checks++; if (rf_load !== 1'b0) begin errors++; $display("[TB] FAIL nop_load_t0: got %b, expected 0", rf_load); end
    exp_b.push_back(bexp_t'{1'b0, 16'h0});
    tick();
    b_req = 1'b0;
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("[TB] FAIL nop_done_t1: got %b, expected 1", b_done); end
    checks++; if (rf_load !== 1'b0) begin errors++; $display("[TB] FAIL nop_load_t1: got %b, expected 0", rf_load); end
    tick();
    drain(3);
  endtask

  // Watchdog so a wedged design still produces a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    test_reset();
    test_write_read();
    test_swap();
    test_starvation();
    test_back_to_back();
    test_reset_mid_swap();
    test_swap_same_and_nop();
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("[TB] FAIL a_pending: got %0d outstanding, expected 0", exp_a.size()); end
    checks++;
    if (exp_b.size() != 0) begin errors++; $display("[TB] FAIL b_pending: got %0d outstanding, expected 0", exp_b.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
